// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - two-stage RV32I OP/OP-IMM decode-and-issue front end for an external combinational ALU
module alu_issue (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_rv1,
  output logic [31:0] alu_rv2,
  input  logic [31:0] alu_rvout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_result,
  output logic        out_we,
  output logic        out_illegal
);

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SLL  = 6'd1;
  localparam logic [5:0] OP_SLT  = 6'd2;
  localparam logic [5:0] OP_SLTU = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_SRL  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_AND  = 6'd7;
  localparam logic [5:0] OP_SRA  = 6'd8;
  localparam logic [5:0] OP_SUB  = 6'd9;
  localparam logic [5:0] OP_ILL  = 6'd63;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic        s1_valid;
  logic [4:0]  s1_rd;
  logic        s1_illegal;

  logic        s2_free;
  logic        accept;

  logic [5:0]  dec_op;
  logic [31:0] dec_rv2;
  logic        dec_illegal;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] shamt_imm;
  logic [31:0] shamt_reg;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign shamt_imm = {27'b0, instr[24:20]};
  assign shamt_reg = {27'b0, rs2_data[4:0]};

  // S2 can take a new entry when empty or draining this cycle; S1 accepts when it empties or moves on.
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready && !flush;

  // Decode the offered instruction into ALU op and operand 2; anything outside OP/OP-IMM is illegal.
  always_comb begin
    dec_op      = OP_ILL;
    dec_rv2     = 32'd0;
    dec_illegal = 1'b1;
    if (opcode == OPC_OPIMM) begin
      dec_rv2     = imm_i;
      dec_illegal = 1'b0;
      case (funct3)
        3'b000: dec_op = OP_ADD;
        3'b010: dec_op = OP_SLT;
        3'b011: dec_op = OP_SLTU;
        3'b100: dec_op = OP_XOR;
        3'b110: dec_op = OP_OR;
        3'b111: dec_op = OP_AND;
        3'b001: begin
          dec_rv2 = shamt_imm;
          if (funct7 == F7_BASE) dec_op = OP_SLL;
          else dec_illegal = 1'b1;
        end
        default: begin
          dec_rv2 = shamt_imm;
          if (funct7 == F7_BASE) dec_op = OP_SRL;
          else if (funct7 == F7_ALT) dec_op = OP_SRA;
          else dec_illegal = 1'b1;
        end
      endcase
    end else if (opcode == OPC_OP) begin
      dec_rv2     = rs2_data;
      dec_illegal = 1'b0;
      if (funct7 == F7_BASE) begin
        case (funct3)
          3'b000:  dec_op = OP_ADD;
          3'b001:  begin dec_op = OP_SLL; dec_rv2 = shamt_reg; end
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101:  begin dec_op = OP_SRL; dec_rv2 = shamt_reg; end
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
        dec_op = OP_SUB;
      end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
        dec_op  = OP_SRA;
        dec_rv2 = shamt_reg;
      end else begin
        dec_illegal = 1'b1;
      end
    end
    if (dec_illegal) begin
      dec_op  = OP_ILL;
      dec_rv2 = 32'd0;
    end
  end

  // S1: decoded operands drive the ALU directly; an empty S1 parks alu_op at illegal but keeps operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      alu_op     <= OP_ILL;
      alu_rv1    <= 32'd0;
      alu_rv2    <= 32'd0;
      s1_rd      <= 5'd0;
      s1_illegal <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      alu_op   <= OP_ILL;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      alu_op     <= dec_op;
      alu_rv1    <= rs1_data;
      alu_rv2    <= dec_rv2;
      s1_rd      <= instr[11:7];
      s1_illegal <= dec_illegal;
    end else if (s1_valid && s2_free) begin
      s1_valid <= 1'b0;
      alu_op   <= OP_ILL;
    end
  end

  // S2: capture the ALU result as S1 advances; hold everything while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_rd      <= 5'd0;
      out_result  <= 32'd0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_rd      <= s1_rd;
        out_result  <= s1_illegal ? 32'd0 : alu_rvout;
        out_we      <= !s1_illegal && (s1_rd != 5'd0);
        out_illegal <= s1_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a behavioural ALU model
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [5:0]  alu_op;
  logic [31:0] alu_rv1;
  logic [31:0] alu_rv2;
  logic [31:0] alu_rvout;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_result;
  logic        out_we;
  logic        out_illegal;

  alu_issue dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_op(alu_op), .alu_rv1(alu_rv1), .alu_rv2(alu_rv2), .alu_rvout(alu_rvout),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_result(out_result), .out_we(out_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Environment ALU: combinational result for the presented op/operands.
  always_comb begin
    alu_rvout = 32'hDEADBEEF;
    case (alu_op)
      6'd0: alu_rvout = alu_rv1 + alu_rv2;
      6'd1: alu_rvout = alu_rv1 << alu_rv2[4:0];
      6'd2: alu_rvout = {31'd0, $signed(alu_rv1) < $signed(alu_rv2)};
      6'd3: alu_rvout = {31'd0, alu_rv1 < alu_rv2};
      6'd4: alu_rvout = alu_rv1 ^ alu_rv2;
      6'd5: alu_rvout = alu_rv1 >> alu_rv2[4:0];
      6'd6: alu_rvout = alu_rv1 | alu_rv2;
      6'd7: alu_rvout = alu_rv1 & alu_rv2;
      6'd8: alu_rvout = $unsigned($signed(alu_rv1) >>> alu_rv2[4:0]);
      6'd9: alu_rvout = alu_rv1 - alu_rv2;
      default: alu_rvout = 32'hDEADBEEF;
    endcase
  end

  typedef struct {
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t vt[12];
  vec_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = sb.pop_front();
        check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
        check("out_result", out_result, e.res);
        check("out_we", {31'd0, out_we}, {31'd0, e.we});
        check("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      end
    end
  end

  // Offer one vector and wait (bounded) until it is accepted; returns just after the accepting edge.
  task automatic send(input vec_t v);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    instr    = v.ins;
    rs1_data = v.a;
    rs2_data = v.b;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(v);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [31:0] held_res;
    logic [4:0]  held_rd;

    vt[0]  = '{32'hFFF08293, 32'd5,        32'd0,        5'd5,  32'd4,        1'b1, 1'b0};
    vt[1]  = '{32'h4020D1B3, 32'h80000000, 32'h00000024, 5'd3,  32'hF8000000, 1'b1, 1'b0};
    vt[2]  = '{32'h00000073, 32'h11111111, 32'h22222222, 5'd0,  32'd0,        1'b0, 1'b1};
    vt[3]  = '{32'h4230D213, 32'h80000000, 32'd0,        5'd4,  32'd0,        1'b0, 1'b1};
    vt[4]  = '{32'h00208033, 32'd3,        32'd4,        5'd0,  32'd7,        1'b0, 1'b0};
    vt[5]  = '{32'h40208333, 32'd10,       32'd3,        5'd6,  32'd7,        1'b1, 1'b0};
    vt[6]  = '{32'hFFB0A393, 32'hFFFFFFF0, 32'd0,        5'd7,  32'd1,        1'b1, 1'b0};
    vt[7]  = '{32'h0020B433, 32'd1,        32'hFFFFFFFF, 5'd8,  32'd1,        1'b1, 1'b0};
    vt[8]  = '{32'h00409493, 32'h12345678, 32'd0,        5'd9,  32'h23456780, 1'b1, 1'b0};
    vt[9]  = '{32'h0FF0C513, 32'h0F0F0F0F, 32'd0,        5'd10, 32'h0F0F0FF0, 1'b1, 1'b0};
    vt[10] = '{32'h002095B3, 32'd3,        32'h00000021, 5'd11, 32'd6,        1'b1, 1'b0};
    vt[11] = '{32'h7F00F613, 32'hFFFFFFFF, 32'd0,        5'd12, 32'h000007F0, 1'b1, 1'b0};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_alu_op", {26'd0, alu_op}, 32'd63);
    check("rst_alu_rv1", alu_rv1, 32'd0);
    check("rst_alu_rv2", alu_rv2, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_we", {31'd0, out_we}, 32'd0);
    @(posedge clk); #1;

    // ADDI: decoded operands right after accept, result two edges later, idle S1 parks at op 63.
    send(vt[0]);
    check("addi_alu_op", {26'd0, alu_op}, 32'd0);
    check("addi_alu_rv1", alu_rv1, 32'd5);
    check("addi_alu_rv2", alu_rv2, 32'hFFFFFFFF);
    @(negedge clk);
    check("addi_not_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("addi_latency2", {31'd0, out_valid}, 32'd1);
    check("idle_alu_op", {26'd0, alu_op}, 32'd63);
    check("idle_rv2_hold", alu_rv2, 32'hFFFFFFFF);

    // SRA register form uses only rs2[4:0].
    send(vt[1]);
    check("sra_alu_rv2", alu_rv2, 32'd4);
    check("sra_alu_op", {26'd0, alu_op}, 32'd8);

    // Back-to-back stream at full throughput.
    for (int i = 2; i < 12; i++) send(vt[i]);
    repeat (3) @(posedge clk); #1;

    // Backpressure: two accepts fill both stages, third waits; outputs stay frozen.
    out_ready = 1'b0;
    send(vt[5]);
    send(vt[8]);
    in_valid = 1'b1; instr = vt[9].ins; rs1_data = vt[9].a; rs2_data = vt[9].b;
    @(negedge clk);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    held_res = out_result;
    held_rd  = out_rd;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_result_stable", out_result, held_res);
      check("bp_rd_stable", {27'd0, out_rd}, {27'd0, held_rd});
      check("bp_in_ready_held", {31'd0, in_ready}, 32'd0);
    end
    check("bp_result_first", held_res, 32'd7);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(vt[9]);
    repeat (4) @(posedge clk); #1;

    // Flush with an instruction offered: nothing in flight survives and nothing is taken.
    send(vt[10]);
    flush = 1'b1; in_valid = 1'b1; instr = vt[11].ins; rs1_data = vt[11].a; rs2_data = vt[11].b;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_alu_op", {26'd0, alu_op}, 32'd63);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_no_accept", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(vt[6]);
    send(vt[7]);
    #2;
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_alu_op", {26'd0, alu_op}, 32'd63);
    check("arst_out_result", out_result, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send(vt[1]);

    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are listed below, one per line: name, direction, width, meaning.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 flush  in  1  synchronous pipeline kill.
REQ-005 in_valid  in  1  instruction offered.
REQ-006 in_ready  out  1  block accepts instruction this cycle.
REQ-007 instr  in  32  RV32I instruction word.
REQ-008 rs1_data  in  32  rs1 register value; sampled with instr.
REQ-009 rs2_data  in  32  rs2 register value; sampled with instr.
REQ-010 alu_op  out  6  op code to ALU: ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, OR=6, AND=7, SRA=8, SUB=9, illegal=63.
REQ-011 alu_rv1  out  32  ALU operand 1.
REQ-012 alu_rv2  out  32  ALU operand 2.
REQ-013 alu_rvout  in  32  combinational ALU result for current alu_op/rv1/rv2.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  consumer accepts result.
REQ-016 out_rd  out  5  destination register.
REQ-017 out_result  out  32  registered result.
REQ-018 out_we  out  1  write enable: 1 iff rd!=0 and not illegal.
REQ-019 out_illegal  out  1  instruction not a legal OP/OP-IMM ALU instruction.

Function
REQ-020 Two registered stages SHALL exist: S1 (decode: op, rv1, rv2, rd, illegal, s1_valid) driving alu_* directly; S2 (result: out_* , out_valid) capturing alu_rvout.
REQ-021 Handshake: transfer on in_valid&&in_ready and on out_valid&&out_ready; accepted instruction on edge N SHALL appear with out_valid=1 after edge N+1 (latency 2) with no backpressure.
REQ-022 s2_free = !out_valid || out_ready; S2 loads when s2_free; S1 advances when s1_valid && s2_free.
REQ-023 in_ready = !s1_valid || s2_free (combinational, no in_valid dependency); full throughput 1 instr/cycle.
REQ-024 Under out_ready=0 with both stages full, all S1/S2 registers SHALL hold; out_* stable while out_valid=1 and out_ready=0.
REQ-025 OP-IMM (opcode 0010011): funct3 000/010/011/100/110/111 -> ADD/SLT/SLTU/XOR/OR/AND with rv2 = sign-extended instr[31:20].
REQ-026 OP-IMM shifts: funct3 001 with funct7 0000000 -> SLL; 101 with 0000000 -> SRL, 0100000 -> SRA; rv2 = {27'b0, instr[24:20]}; other funct7 illegal.
REQ-027 OP (opcode 0110011): funct7 0000000 maps funct3 as REQ-025/026; funct7 0100000 with funct3 000 -> SUB, 101 -> SRA; other funct7/funct3 combos illegal.
REQ-028 OP register shifts SHALL present rv2 = {27'b0, rs2_data[4:0]}; non-shift OP uses rv2 = rs2_data.
REQ-029 rv1 = rs1_data for all legal instructions; rd = instr[11:7].
REQ-030 Illegal instruction (any other opcode or encoding) SHALL be accepted, carried with alu_op=63, out_result=0, out_illegal=1, out_we=0.
REQ-031 rd=0: result computed and delivered, out_we=0.
REQ-032 flush=1 SHALL clear s1_valid and out_valid at the next edge, overriding any simultaneous accept; in_ready is ignored that cycle (no instruction taken).
REQ-033 When s1_valid=0, alu_op SHALL read 63 and alu_rv1/alu_rv2 retain prior values.

Reset
REQ-034 reset_n=0 SHALL asynchronously clear: s1_valid=0, out_valid=0, alu_op=63, alu_rv1=0, alu_rv2=0, out_rd=0, out_result=0, out_we=0, out_illegal=0.
REQ-035 Reset mid-operation SHALL discard all in-flight instructions; first accept is possible in the first cycle after reset_n rises (in_ready=1).

Verification
REQ-036 ADDI x5,x1,-1 (0xFFF08293), rs1=5 -> alu_op=0, alu_rv2=0xFFFFFFFF, two cycles later out_result=4, out_rd=5, out_we=1.
REQ-037 SRA x3,x1,x2 (0x4020D1B3), rs1=0x80000000, rs2=0x00000024 -> alu_rv2=4, out_result=0xF8000000.
REQ-038 Back-to-back 3 instrs with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts, out_* stable, all 3 results delivered in order once out_ready=1.
REQ-039 instr=0x00000073 (ECALL) and SRLI with funct7 0100001 -> out_illegal=1, out_result=0, out_we=0.
REQ-040 ADD x0,x1,x2 -> out_valid=1, out_we=0; flush asserted with in_valid=1 -> next cycle s1_valid=0, out_valid=0, instruction not accepted.
REQ-041 reset_n pulsed low while both stages full -> out_valid=0, alu_op=63 immediately, without clock edge.
